// File: rtl/serializador_ctrl_if.sv
// Requester/registro-side bundle for serializador_ctrl.
// master: the requester that owns DATA_IN/VALID_IN/mode inputs and observes status.
// slave:  the controller that drives status and the registro control lines.
interface serializador_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] DATA_IN;
  logic             VALID_IN;
  logic             LSB_FIRST;
  logic             ROTATE;
  logic             ABORT;
  logic             READY;
  logic             BUSY;
  logic             BIT_VALID;
  logic             DONE;
  logic [WIDTH-1:0] REG_D;
  logic [1:0]       REG_MODO;
  logic             REG_DIR;
  logic             REG_ENB;
  logic             REG_S_IN;

  modport master (
    output DATA_IN, VALID_IN, LSB_FIRST, ROTATE, ABORT,
    input  READY, BUSY, BIT_VALID, DONE,
    input  REG_D, REG_MODO, REG_DIR, REG_ENB, REG_S_IN
  );

  modport slave (
    input  DATA_IN, VALID_IN, LSB_FIRST, ROTATE, ABORT,
    output READY, BUSY, BIT_VALID, DONE,
    output REG_D, REG_MODO, REG_DIR, REG_ENB, REG_S_IN
  );
endinterface

// File: rtl/serializador_ctrl.sv
// Controller that sequences a universal shift register (registro) through
// LOAD, WIDTH shift cycles and a DONE pulse for each accepted word.
// REG_MODO codes follow definitions.v: PUSH=00, CYCLE=01, LOAD=10.
module serializador_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  serializador_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] MODO_PUSH  = 2'b00;
  localparam logic [1:0] MODO_CYCLE = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;

  logic             ready, busy, bit_valid, done, enb;
  logic [1:0]       modo;

  // State, counter and acceptance latches; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      reg_d_q <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg_d_q <= reg_d_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

  // Next-state/output decode; RST masks the status outputs combinationally.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reg_d_d   = reg_d_q;
    dir_d     = dir_q;
    rot_d     = rot_q;
    ready     = 1'b0;
    busy      = 1'b1;
    bit_valid = 1'b0;
    done      = 1'b0;
    enb       = 1'b0;
    modo      = MODO_LOAD;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (bus.VALID_IN) begin
          reg_d_d = bus.DATA_IN;
          dir_d   = bus.LSB_FIRST;
          rot_d   = bus.ROTATE;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        enb     = 1'b1;
        cnt_d   = '0;
        state_d = bus.ABORT ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        enb       = 1'b1;
        bit_valid = 1'b1;
        modo      = rot_q ? MODO_CYCLE : MODO_PUSH;
        // Counter runs up to WIDTH on the final cycle; CW bits keep it from wrapping.
        cnt_d     = cnt_q + CW'(1);
        if (bus.ABORT) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (RST) begin
      ready     = 1'b0;
      busy      = 1'b0;
      bit_valid = 1'b0;
      done      = 1'b0;
      enb       = 1'b0;
      modo      = MODO_LOAD;
    end
  end

  assign bus.READY     = ready;
  assign bus.BUSY      = busy;
  assign bus.BIT_VALID = bit_valid;
  assign bus.DONE      = done;
  assign bus.REG_D     = reg_d_q;
  assign bus.REG_MODO  = modo;
  assign bus.REG_DIR   = dir_q;
  assign bus.REG_ENB   = enb;
  assign bus.REG_S_IN  = 1'b0;
endmodule

// File: tb/tb_serializador_ctrl.sv
// Testbench for serializador_ctrl: drives directed and random words, models
// the attached registro, and checks the controller against a per-word
// cycle schedule and the expected serial bit stream.
module tb_serializador_ctrl;
  localparam int W   = 4;
  localparam int PER = W + 3;

  localparam logic [1:0] M_PUSH  = 2'b00;
  localparam logic [1:0] M_CYCLE = 2'b01;
  localparam logic [1:0] M_LOAD  = 2'b10;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  serializador_ctrl_if #(.WIDTH(W)) bif ();

  serializador_ctrl #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Behavioural registro driven by the controller outputs.
  logic [W-1:0] q_m = '0;
  logic         s_out;
  assign s_out = bif.REG_DIR ? q_m[0] : q_m[W-1];

  always @(posedge clk) begin
    if (bif.REG_ENB) begin
      case (bif.REG_MODO)
        M_LOAD:  q_m <= bif.REG_D;
        M_PUSH:  q_m <= bif.REG_DIR ? {bif.REG_S_IN, q_m[W-1:1]} : {q_m[W-2:0], bif.REG_S_IN};
        M_CYCLE: q_m <= bif.REG_DIR ? {q_m[0], q_m[W-1:1]} : {q_m[W-2:0], q_m[W-1]};
        default: q_m <= q_m;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 32'(bif.READY), 0);
    chk("rst_busy", 32'(bif.BUSY), 0);
    chk("rst_bitvalid", 32'(bif.BIT_VALID), 0);
    chk("rst_done", 32'(bif.DONE), 0);
    chk("rst_enb", 32'(bif.REG_ENB), 0);
    chk("rst_modo", 32'(bif.REG_MODO), 32'(M_LOAD));
    chk("rst_sin", 32'(bif.REG_S_IN), 0);
  endtask

  // Offers one word at an IDLE negedge and follows it to the next IDLE negedge.
  // abort_j: shift cycle (1-based) during which ABORT is high, 0 = none.
  task automatic run_word(input logic [W-1:0] data, input logic lsb, input logic rot,
                          input int abort_j, input logic abort_idle);
    int last;
    int nbits;
    int j;
    logic exp_bit;
    last  = (abort_j != 0) ? abort_j + 2 : PER;
    nbits = 0;
    bif.DATA_IN   = data;
    bif.LSB_FIRST = lsb;
    bif.ROTATE    = rot;
    bif.VALID_IN  = 1'b1;
    bif.ABORT     = abort_idle;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bif.VALID_IN  = 1'b0;
        bif.DATA_IN   = W'($urandom);
        bif.LSB_FIRST = 1'($urandom);
        bif.ROTATE    = 1'($urandom);
      end
      chk("reg_d", 32'(bif.REG_D), 32'(data));
      chk("reg_dir", 32'(bif.REG_DIR), 32'(lsb));
      chk("s_in", 32'(bif.REG_S_IN), 0);
      if (k == last) begin
        chk("idle_ready", 32'(bif.READY), 1);
        chk("idle_busy", 32'(bif.BUSY), 0);
        chk("idle_enb", 32'(bif.REG_ENB), 0);
        chk("idle_done", 32'(bif.DONE), 0);
      end else if (k == 1) begin
        chk("load_ready", 32'(bif.READY), 0);
        chk("load_busy", 32'(bif.BUSY), 1);
        chk("load_enb", 32'(bif.REG_ENB), 1);
        chk("load_modo", 32'(bif.REG_MODO), 32'(M_LOAD));
        chk("load_bitvalid", 32'(bif.BIT_VALID), 0);
      end else if (k == W + 2) begin
        chk("done_pulse", 32'(bif.DONE), 1);
        chk("done_enb", 32'(bif.REG_ENB), 0);
        chk("done_bitvalid", 32'(bif.BIT_VALID), 0);
        chk("done_busy", 32'(bif.BUSY), 1);
        chk("done_q", 32'(q_m), rot ? 32'(data) : 0);
      end else begin
        j = k - 1;
        exp_bit = lsb ? data[j-1] : data[W-j];
        chk("shift_bitvalid", 32'(bif.BIT_VALID), 1);
        chk("shift_enb", 32'(bif.REG_ENB), 1);
        chk("shift_ready", 32'(bif.READY), 0);
        chk("shift_done", 32'(bif.DONE), 0);
        chk("shift_modo", 32'(bif.REG_MODO), rot ? 32'(M_CYCLE) : 32'(M_PUSH));
        chk("serial_bit", 32'(s_out), 32'(exp_bit));
      end
      if (bif.BIT_VALID) nbits++;
      bif.ABORT = (abort_j != 0) && (k == abort_j + 1);
    end
    chk("bit_count", 32'(nbits), (abort_j != 0) ? 32'(abort_j) : 32'(W));
    bif.ABORT = 1'b0;
  endtask

  initial begin
    logic [W-1:0] acc;
    int           ph;
    bif.DATA_IN   = '0;
    bif.VALID_IN  = 1'b0;
    bif.LSB_FIRST = 1'b0;
    bif.ROTATE    = 1'b0;
    bif.ABORT     = 1'b0;
    acc           = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    chk("rst_reg_d", 32'(bif.REG_D), 0);
    chk("rst_reg_dir", 32'(bif.REG_DIR), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bif.READY), 1);
    chk("post_rst_busy", 32'(bif.BUSY), 0);

    // Directed words: MSB-first PUSH, LSB-first CYCLE, abort on 2nd shift, abort with valid in IDLE
    run_word(4'b1101, 1'b0, 1'b0, 0, 1'b0);
    run_word(4'b0110, 1'b1, 1'b1, 0, 1'b0);
    run_word(4'b1011, 1'b0, 1'b1, 2, 1'b0);
    run_word(4'b1001, 1'b1, 1'b0, 0, 1'b1);

    // Reset asserted on the 3rd shift cycle
    bif.DATA_IN  = 4'b1110;
    bif.VALID_IN = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bif.VALID_IN = 1'b0;
    end
    chk("pre_rst_bitvalid", 32'(bif.BIT_VALID), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    chk("midrst_reg_d", 32'(bif.REG_D), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(bif.READY), 1);
    chk("midrst_busy", 32'(bif.BUSY), 0);

    // VALID_IN held high with DATA_IN changing every cycle
    bif.VALID_IN = 1'b1;
    for (int i = 0; i < 3 * PER; i++) begin
      ph = i % PER;
      chk("cont_ready", 32'(bif.READY), (ph == 0) ? 1 : 0);
      chk("cont_busy", 32'(bif.BUSY), (ph == 0) ? 0 : 1);
      if (ph == 1) chk("cont_word", 32'(bif.REG_D), 32'(acc));
      bif.DATA_IN = W'($urandom);
      if (ph == 0) acc = bif.DATA_IN;
      @(negedge clk);
    end
    bif.VALID_IN = 1'b0;

    // Random words with occasional aborts
    for (int n = 0; n < 20; n++) begin
      run_word(W'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0,
               1'($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
